// File: rtl/mult_mac_sequencer_pkg.sv
// Shared types and constants for the multiply-accumulate sequencer.
package mult_pkg;

    // Default configuration shared by the sequencer and its accumulator.
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned GUARD_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned acc_width(input int unsigned w, input int unsigned g);
        return 2 * w + g;
    endfunction

    // The multiplier's bit counter is 5 bits wide, so operands cannot exceed 31 bits.
    function automatic bit width_ok(input int unsigned w);
        return (w >= 1) && (w <= 31);
    endfunction

    localparam int unsigned ACC_W    = acc_width(WIDTH_DEF, GUARD_DEF);
    localparam bit          WIDTH_OK = width_ok(WIDTH_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StArm,
        StWait
    } state_e;

endpackage

// File: rtl/mult_mac_sequencer_if.sv
// Operand stream into the sequencer: valid/ready handshake with a last marker.
interface mult_mac_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mult_mac_sequencer_acc.sv
// Accumulator for the sequencer: running sum, term counter and result capture.
// Optional macro MAC_SATURATE_EN clamps the sum at all ones and adds acc_sat.
module mac_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned AccW  = ACC_W,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ProdW = 2 * WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en_i,
    input  logic             last_i,
    input  logic [ProdW-1:0] product_i,
    output logic             acc_valid_o,
    output logic [AccW-1:0]  acc_out_o,
    output logic [CNT_W-1:0] acc_count_o
`ifdef MAC_SATURATE_EN
    ,
    output logic             acc_sat_o
`endif
);

    logic [AccW-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AccW-1:0]  out_q, out_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             valid_q, valid_d;
    logic [AccW:0]    sum_full;
    logic [AccW-1:0]  sum;
    logic [CNT_W-1:0] cnt_inc;

    // One extra bit catches the carry out of the ACC_W-wide sum.
    assign sum_full = {1'b0, acc_q} + {{(AccW + 1 - ProdW){1'b0}}, product_i};
    assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef MAC_SATURATE_EN
    logic sat_q, sat_d;
    logic sat_out_q, sat_out_d;
    logic term_sat;

    // Clamp the sum to all ones whenever the add carries out.
    always_comb begin
        term_sat = sum_full[AccW];
        sum      = term_sat ? {AccW{1'b1}} : sum_full[AccW-1:0];
    end
`else
    // Modulo 2^ACC_W: the carry is simply dropped.
    always_comb begin
        sum = sum_full[AccW-1:0];
    end
`endif

    // Next-state: accumulate on add_en, capture and clear on the last term.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_cnt_d = out_cnt_q;
        valid_d   = 1'b0;
`ifdef MAC_SATURATE_EN
        sat_d     = sat_q;
        sat_out_d = sat_out_q;
`endif
        if (add_en_i) begin
            if (last_i) begin
                out_d     = sum;
                out_cnt_d = cnt_inc;
                valid_d   = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
`ifdef MAC_SATURATE_EN
                sat_out_d = sat_q | term_sat;
                sat_d     = 1'b0;
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
`ifdef MAC_SATURATE_EN
                sat_d = sat_q | term_sat;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_cnt_q <= '0;
            valid_q   <= 1'b0;
`ifdef MAC_SATURATE_EN
            sat_q     <= 1'b0;
            sat_out_q <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_cnt_q <= out_cnt_d;
            valid_q   <= valid_d;
`ifdef MAC_SATURATE_EN
            sat_q     <= sat_d;
            sat_out_q <= sat_out_d;
`endif
        end
    end

    assign acc_valid_o = valid_q;
    assign acc_out_o   = out_q;
    assign acc_count_o = out_cnt_q;
`ifdef MAC_SATURATE_EN
    assign acc_sat_o   = sat_out_q;
`endif

endmodule

// File: rtl/mult_mac_sequencer.sv
// Serial multiply-accumulate sequencer driving an external streamlined multiplier.
// Optional macro MAC_SATURATE_EN: saturating accumulation plus acc_sat output.
module mult_mac_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned GUARD = GUARD_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned AccW = acc_width(WIDTH, GUARD)
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_mac_sequencer_if.slave   in_if,
    output logic                  mult_start,
    output logic [WIDTH-1:0]      mult_ina,
    output logic [WIDTH-1:0]      mult_inb,
    input  logic [2*WIDTH-1:0]    mult_out,
    input  logic                  mult_ready,
    output logic                  acc_valid,
    output logic [AccW-1:0]       acc_out,
    output logic [CNT_W-1:0]      acc_count
`ifdef MAC_SATURATE_EN
    ,
    output logic                  acc_sat
`endif
);

    if (!width_ok(WIDTH) || !WIDTH_OK) begin : g_bad_width
        $error("mult_mac_sequencer: WIDTH must be in 1..31");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ina_q, ina_d;
    logic [WIDTH-1:0] inb_q, inb_d;
    logic             last_q, last_d;
    logic             accept;
    logic             add_en;

    assign accept = (state_q == StIdle) && in_if.in_valid;
    assign add_en = (state_q == StWait) && mult_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ARM exists to skip the stale ready from the previous product.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_if.in_valid) state_d = StIssue;
            StIssue: state_d = StArm;
            StArm:   state_d = StWait;
            StWait:  if (mult_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_if.in_ready = (state_q == StIdle);
        mult_start     = (state_q == StIssue);
    end

    // Operand capture: held stable from the handshake until the return to IDLE.
    always_comb begin
        ina_d  = ina_q;
        inb_d  = inb_q;
        last_d = last_q;
        if (accept) begin
            ina_d  = in_if.in_a;
            inb_d  = in_if.in_b;
            last_d = in_if.in_last;
        end
    end

    // Operand and last-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ina_q  <= '0;
            inb_q  <= '0;
            last_q <= 1'b0;
        end else begin
            ina_q  <= ina_d;
            inb_q  <= inb_d;
            last_q <= last_d;
        end
    end

    assign mult_ina = ina_q;
    assign mult_inb = inb_q;

    mac_accumulator #(
        .AccW  (AccW),
        .CNT_W (CNT_W),
        .ProdW (2 * WIDTH)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .add_en_i    (add_en),
        .last_i      (last_q),
        .product_i   (mult_out),
        .acc_valid_o (acc_valid),
        .acc_out_o   (acc_out),
        .acc_count_o (acc_count)
`ifdef MAC_SATURATE_EN
        ,
        .acc_sat_o   (acc_sat)
`endif
    );

endmodule

// File: tb/tb_mult_mac_sequencer.sv
// Self-checking bench for mult_mac_sequencer with a behavioural multiplier and scoreboard.
module tb_mult_mac_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned GUARD = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned AccW  = 2 * WIDTH + GUARD;
    localparam logic [63:0] AccMax = (64'd1 << AccW) - 64'd1;

    logic                 clk;
    logic                 rst;
    logic                 mult_start;
    logic [WIDTH-1:0]     mult_ina;
    logic [WIDTH-1:0]     mult_inb;
    logic [2*WIDTH-1:0]   mult_out;
    logic                 mult_ready;
    logic                 acc_valid;
    logic [AccW-1:0]      acc_out;
    logic [CNT_W-1:0]     acc_count;
    logic                 acc_sat;

    mult_mac_sequencer_if #(.WIDTH(WIDTH)) in_if ();

    mult_mac_sequencer #(
        .WIDTH (WIDTH),
        .GUARD (GUARD),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (in_if),
        .mult_start (mult_start),
        .mult_ina   (mult_ina),
        .mult_inb   (mult_inb),
        .mult_out   (mult_out),
        .mult_ready (mult_ready),
        .acc_valid  (acc_valid),
        .acc_out    (acc_out),
        .acc_count  (acc_count)
`ifdef MAC_SATURATE_EN
        ,
        .acc_sat    (acc_sat)
`endif
    );

`ifndef MAC_SATURATE_EN
    assign acc_sat = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multiplier: no reset; ready drops when start is sampled and
    // rises WIDTH edges later with the product.
    logic [WIDTH-1:0] m_a, m_b;
    logic [4:0]       m_cnt;
    logic             m_busy;
    initial begin
        m_busy     = 1'b0;
        m_cnt      = '0;
        mult_ready = 1'b1;
        mult_out   = '0;
    end
    always @(posedge clk) begin
        if (mult_start) begin
            m_a        <= mult_ina;
            m_b        <= mult_inb;
            m_cnt      <= '0;
            m_busy     <= 1'b1;
            mult_ready <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 5'(WIDTH - 1)) begin
                mult_ready <= 1'b1;
                mult_out   <= m_a * m_b;
                m_busy     <= 1'b0;
            end
            m_cnt <= m_cnt + 5'd1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] acc;
        logic [63:0] cnt;
        logic        sat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_acc;
    logic [63:0] m_terms;
    logic        m_sat;

    task automatic model_clear();
        m_acc   = '0;
        m_terms = '0;
        m_sat   = 1'b0;
    endtask

    task automatic model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic last);
        exp_t e;
        m_acc   = m_acc + 64'(a) * 64'(b);
`ifdef MAC_SATURATE_EN
        if (m_acc > AccMax) begin
            m_acc = AccMax;
            m_sat = 1'b1;
        end
`else
        m_acc = m_acc & AccMax;
`endif
        m_terms = (m_terms + 64'd1) & 64'hFF;
        if (last) begin
            e.acc = m_acc;
            e.cnt = m_terms;
            e.sat = m_sat;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Output monitor: scoreboard compare, single-cycle valid, held outputs.
    int          start_pulses = 0;
    int          valid_pulses = 0;
    logic        prev_valid   = 1'b0;
    logic        prev_rst     = 1'b1;
    logic [63:0] prev_acc     = '0;
    logic [63:0] prev_cnt     = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !prev_rst) begin
            if (mult_start) start_pulses++;
            if (acc_valid) begin
                valid_pulses++;
                if (prev_valid) check("acc_valid_back_to_back", 64'd1, 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_acc_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("acc_out", 64'(acc_out), e.acc);
                    check("acc_count", 64'(acc_count), e.cnt);
`ifdef MAC_SATURATE_EN
                    check("acc_sat", 64'(acc_sat), 64'(e.sat));
`endif
                end
            end else if (64'(acc_out) != prev_acc || 64'(acc_count) != prev_cnt) begin
                check("acc_held_without_valid", 64'(acc_out), prev_acc);
            end
        end
        prev_valid = acc_valid;
        prev_rst   = rst;
        prev_acc   = 64'(acc_out);
        prev_cnt   = 64'(acc_count);
    end

    // Offer a pair from the next falling edge; returns after the accepting edge.
    // in_valid stays high so a following call keeps the source holding data.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic last, output int waited);
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_a     = a;
        in_if.in_b     = b;
        in_if.in_last  = last;
        waited         = 0;
        while (!in_if.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_if.in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            model_add(a, b, last);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_if.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_if.in_ready), 64'd1);
        check({tag, "_mult_start"}, 64'(mult_start), 64'd0);
        check({tag, "_mult_ina"}, 64'(mult_ina), 64'd0);
        check({tag, "_mult_inb"}, 64'(mult_inb), 64'd0);
        check({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
        check({tag, "_acc_out"}, 64'(acc_out), 64'd0);
        check({tag, "_acc_count"}, 64'(acc_count), 64'd0);
        check({tag, "_acc_sat"}, 64'(acc_sat), 64'd0);
    endtask

    initial begin
        int w;
        int s0;
        int v0;
        rst            = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_a     = '0;
        in_if.in_b     = '0;
        in_if.in_last  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single pair 3*5.
        s0 = start_pulses;
        v0 = valid_pulses;
        send(8'd3, 8'd5, 1'b1, w);
        go_idle();
        drain("single_drain");
        check("single_start_pulses", 64'(start_pulses - s0), 64'd1);
        check("single_valid_pulses", 64'(valid_pulses - v0), 64'd1);
        check("single_in_ready", 64'(in_if.in_ready), 64'd1);

        // Three full-scale terms, one result only.
        v0 = valid_pulses;
        for (int i = 0; i < 3; i++) send(8'd255, 8'd255, i == 2, w);
        go_idle();
        drain("three_drain");
        check("three_valid_pulses", 64'(valid_pulses - v0), 64'd1);

        // Seventeen full-scale terms overflow the 20-bit accumulator.
        for (int i = 0; i < 17; i++) send(8'd255, 8'd255, i == 16, w);
        go_idle();
        drain("seventeen_drain");

        // Second pair held on the bus while the first one is in flight.
        s0 = start_pulses;
        send(8'd10, 8'd20, 1'b0, w);
        send(8'd30, 8'd40, 1'b1, w);
        check("held_pair_waited_ge", 64'(w >= int'(WIDTH + 2)), 64'd1);
        go_idle();
        drain("held_drain");
        check("held_start_pulses", 64'(start_pulses - s0), 64'd2);

        // Reset while waiting on the multiplier, then a fresh sum.
        send(8'd9, 8'd9, 1'b0, w);
        go_idle();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_reset_outputs("midreset");
        send(8'd2, 8'd7, 1'b1, w);
        go_idle();
        drain("after_reset_drain");

        // Zero product still counts as a term.
        v0 = valid_pulses;
        send(8'd0, 8'd200, 1'b1, w);
        go_idle();
        drain("zero_drain");
        check("zero_valid_pulses", 64'(valid_pulses - v0), 64'd1);

        // Random short sums against the model.
        for (int k = 0; k < 4; k++) begin
            int len = int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                send(WIDTH'($urandom), WIDTH'($urandom), i == len - 1, w);
            end
            go_idle();
            drain("random_drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
